// File: rtl/pin_name_rx.sv
// UART 8N1 receiver that assembles fixed-length ASCII pin names, with the first character in the MSB byte.
// Complete names are presented on a valid/ready interface. Framing errors, glitches and overruns are reported as pulses.
module pin_name_rx #(
    parameter int NAME_BYTES       = 4,
    parameter int PRESCALE_W       = 16,
    parameter int GAP_TIMEOUT_BITS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rxd,
    input  logic [PRESCALE_W-1:0]   prescale,
    output logic [8*NAME_BYTES-1:0] name_out,
    output logic                    name_valid,
    input  logic                    name_ready,
    output logic                    frame_error,
    output logic                    glitch,
    output logic                    overrun
);

    localparam int NAME_W = 8 * NAME_BYTES;
    localparam int CNT_W  = $clog2(NAME_BYTES + 1);
    localparam int GAP_W  = PRESCALE_W + $clog2(GAP_TIMEOUT_BITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK   // bad stop bit seen: wait for the line to return high
    } state_t;

    logic                  rxd_meta;
    logic                  rxs;
    state_t                state_q,   state_d;
    logic [PRESCALE_W-1:0] cnt_q,     cnt_d;
    logic [PRESCALE_W-1:0] bit_len_q, bit_len_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [7:0]            shift_q,   shift_d;
    logic [NAME_W-1:0]     asm_q,     asm_d;
    logic [CNT_W-1:0]      count_q,   count_d;
    logic [GAP_W-1:0]      gap_q,     gap_d;
    logic [NAME_W-1:0]     name_out_d;
    logic                  valid_d;
    logic                  ferr_d;
    logic                  glitch_d;
    logic                  ovr_d;
    logic [PRESCALE_W-1:0] eff_len;
    logic [GAP_W-1:0]      gap_limit;

    assign eff_len   = (prescale < PRESCALE_W'(2)) ? PRESCALE_W'(2) : prescale;
    assign gap_limit = GAP_W'(GAP_TIMEOUT_BITS) * GAP_W'(bit_len_q);

    always_comb begin
        // NOTE: every signal gets a default first, so no path through this block can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_len_d  = bit_len_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        asm_d      = asm_q;
        count_d    = count_q;
        gap_d      = '0;
        name_out_d = name_out;
        valid_d    = name_valid;
        ferr_d     = 1'b0;
        glitch_d   = 1'b0;
        ovr_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d   = START;
                    bit_len_d = eff_len;
                    cnt_d     = (eff_len >> 1) - PRESCALE_W'(1);
                end else if (count_q != '0) begin
                    if (gap_q + GAP_W'(1) >= gap_limit) count_d = '0;
                    else                                gap_d   = gap_q + GAP_W'(1);
                end
            end
            START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - PRESCALE_W'(1);
                end else if (!rxs) begin
                    state_d   = DATA;
                    cnt_d     = bit_len_q - PRESCALE_W'(1);
                    bit_idx_d = '0;
                end else begin
                    glitch_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - PRESCALE_W'(1);
                end else begin
                    shift_d   = {rxs, shift_q[7:1]};
                    cnt_d     = bit_len_q - PRESCALE_W'(1);
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - PRESCALE_W'(1);
                end else if (rxs) begin
                    for (int i = 0; i < NAME_BYTES; i++)
                        if (count_q == CNT_W'(NAME_BYTES - 1 - i)) asm_d[8*i +: 8] = shift_q;
                    count_d = count_q + CNT_W'(1);
                    state_d = IDLE;
                end else begin
                    ferr_d  = 1'b1;
                    count_d = '0;
                    state_d = BREAK;
                end
            end
            BREAK: begin
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A completion takes priority over a transfer, so valid stays high when both happen in the same cycle.
        if (count_q == CNT_W'(NAME_BYTES)) begin
            name_out_d = asm_q;
            valid_d    = 1'b1;
            count_d    = '0;
            ovr_d      = name_valid && !name_ready;
        end else if (name_valid && name_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments only, so every register samples the pre-edge values.
        if (rst) begin
            rxd_meta    <= 1'b1;
            rxs         <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_len_q   <= PRESCALE_W'(2);
            bit_idx_q   <= '0;
            shift_q     <= '0;
            asm_q       <= '0;
            count_q     <= '0;
            gap_q       <= '0;
            name_out    <= '0;
            name_valid  <= 1'b0;
            frame_error <= 1'b0;
            glitch      <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            rxd_meta    <= rxd;
            rxs         <= rxd_meta;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_len_q   <= bit_len_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            asm_q       <= asm_d;
            count_q     <= count_d;
            gap_q       <= gap_d;
            name_out    <= name_out_d;
            name_valid  <= valid_d;
            frame_error <= ferr_d;
            glitch      <= glitch_d;
            overrun     <= ovr_d;
        end
    end

endmodule

// File: tb/tb_pin_name_rx.sv
// Directed bench for pin_name_rx: a character-level model predicts names and error pulses.
// A negedge monitor checks the handshake and every loaded name against that prediction.
module tb_pin_name_rx;

    localparam int NB  = 4;
    localparam int GAP = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rxd = 1'b1;
    logic [15:0]   prescale = 16'd8;
    logic [8*NB-1:0] name_out;
    logic          name_valid;
    logic          name_ready = 1'b1;
    logic          frame_error, glitch, overrun;

    pin_name_rx #(.NAME_BYTES(NB), .PRESCALE_W(16), .GAP_TIMEOUT_BITS(GAP)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .prescale(prescale),
        .name_out(name_out), .name_valid(name_valid), .name_ready(name_ready),
        .frame_error(frame_error), .glitch(glitch), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string what, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", what, act, exp);
        end
    endtask

    // Character-level model: the bench feeds it before each stop bit is driven.
    logic [7:0]      partial[$];
    logic [8*NB-1:0] exp_names[$];
    int exp_glitch = 0, exp_ferr = 0, exp_ovr = 0;
    bit pending = 0;
    int bl = 8;

    task automatic model_char(input logic [7:0] c, input bit good);
        logic [8*NB-1:0] nm;
        if (!good) begin
            partial.delete();
            exp_ferr++;
        end else begin
            partial.push_back(c);
            if (partial.size() == NB) begin
                nm = '0;
                foreach (partial[i]) nm = {nm[8*NB-9:0], partial[i]};
                exp_names.push_back(nm);
                if (pending && !name_ready) exp_ovr++;
                pending = !name_ready;
                partial.delete();
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_char(input logic [7:0] c, input bit good);
        rxd = 1'b0;
        tick(bl);
        for (int i = 0; i < 8; i++) begin
            rxd = c[i];
            tick(bl);
        end
        model_char(c, good);
        rxd = good;
        tick(bl);
        rxd = 1'b1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i], 1'b1);
    endtask

    // The gap is measured from the mid-stop sample, so n idle bits is a gap of n+0.5 bit-times.
    task automatic idle_bits(input int n);
        rxd = 1'b1;
        tick(n * bl);
        if (n >= GAP) partial.delete();
    endtask

    // Monitor state and observed pulse counts.
    int glitch_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, valid_cycles = 0;
    logic [8*NB-1:0] last_name = '0, name_q = '0;
    bit valid_q = 0, accepted_q = 0, glitch_q = 0, ferr_q = 0, ovr_q = 0;

    always @(negedge clk) begin
        bit load;
        if (rst) begin
            valid_q = 0; accepted_q = 0; name_q = '0;
            glitch_q = 0; ferr_q = 0; ovr_q = 0;
        end else begin
            load = name_valid && (!valid_q || accepted_q || overrun);
            if (load) begin
                check("name_expected", exp_names.size() != 0, 1);
                if (exp_names.size() != 0) check("name_out", name_out, exp_names.pop_front());
                last_name = name_out;
                name_q = name_out;
            end else if (name_valid) begin
                check("name_hold", name_out, name_q);
            end
            if (valid_q && !name_valid) check("valid_drop_needs_accept", accepted_q, 1);
            if (name_valid) valid_cycles++;
            if (glitch)      begin glitch_cnt++; check("glitch_width", glitch_q, 0); end
            if (frame_error) begin ferr_cnt++;   check("frame_error_width", ferr_q, 0); end
            if (overrun)     begin ovr_cnt++;    check("overrun_width", ovr_q, 0); end
            valid_q = name_valid;
            accepted_q = name_valid && name_ready;
            glitch_q = glitch; ferr_q = frame_error; ovr_q = overrun;
        end
    end

    task automatic end_test(input string tag);
        check({tag, "_names_left"}, exp_names.size(), 0);
        check({tag, "_glitch_cnt"}, glitch_cnt, exp_glitch);
        check({tag, "_ferr_cnt"}, ferr_cnt, exp_ferr);
        check({tag, "_ovr_cnt"}, ovr_cnt, exp_ovr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        check("reset_name_out", name_out, 0);
        check("reset_valid", name_valid, 0);
        check("reset_frame_error", frame_error, 0);
        check("reset_glitch", glitch, 0);
        check("reset_overrun", overrun, 0);
        rst = 1'b0;
        idle_bits(2);

        // Back-to-back name, consumer always ready.
        valid_cycles = 0;
        send_str("AF12");
        idle_bits(3);
        check("t1_name", last_name, 32'h41463132);
        check("t1_valid_cycles", valid_cycles, 1);
        end_test("t1");

        // Consumer stalls: the first name is held, then overwritten once.
        name_ready = 1'b0;
        send_str("AF12");
        send_str("B7");
        check("t2_held_name", name_out, 32'h41463132);
        check("t2_held_valid", name_valid, 1);
        send_str("00");
        idle_bits(3);
        check("t2_overwrite_name", name_out, 32'h42373030);
        check("t2_overwrite_valid", name_valid, 1);
        check("t2_overrun_pulses", ovr_cnt, 1);
        name_ready = 1'b1;
        pending = 0;
        tick(2);
        check("t2_valid_after_accept", name_valid, 0);
        end_test("t2");

        // Short low glitch at prescale 16.
        prescale = 16'd16;
        bl = 16;
        exp_glitch++;
        rxd = 1'b0;
        tick(2);
        rxd = 1'b1;
        idle_bits(2);
        check("t3_glitch_pulses", glitch_cnt, 1);
        send_str("AF12");
        idle_bits(3);
        check("t3_name", last_name, 32'h41463132);
        end_test("t3");

        // Bad stop bit, then a clean name.
        prescale = 16'd8;
        bl = 8;
        send_char("A", 1'b0);
        idle_bits(2);
        send_str("AF12");
        idle_bits(3);
        check("t4_frame_error_pulses", ferr_cnt, 1);
        check("t4_name", last_name, 32'h41463132);
        end_test("t4");

        // The partial name is discarded by the gap timeout.
        send_str("AF");
        idle_bits(17);
        send_str("12AF");
        idle_bits(3);
        check("t5_name", last_name, 32'h31324146);
        end_test("t5");

        // Reset in the middle of the third character.
        send_str("AF");
        rxd = 1'b0;
        tick(bl);
        for (int i = 0; i < 3; i++) begin
            rxd = (8'h31 >> i) & 8'h01;
            tick(bl);
        end
        rst = 1'b1;
        rxd = 1'b1;
        tick(1);
        check("t6_reset_name_out", name_out, 0);
        check("t6_reset_valid", name_valid, 0);
        partial.delete();
        tick(1);
        rst = 1'b0;
        idle_bits(4);
        send_str("AF12");
        idle_bits(3);
        check("t6_name", last_name, 32'h41463132);
        end_test("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
